pipelined_skip_adder: RTL and testbench

Parametrised, pipelined carry-skip adder/subtractor with a valid/ready stream interface. It generalises the team's fixed 4-bit-block carry-skip adder to configurable width, block size and pipeline depth, and adds subtract mode, signed-overflow and zero flags, and backpressure. It sits in the arithmetic datapath between operand-fetch and writeback stages that issue one operation per cycle.

---
 rtl/pipelined_skip_adder.sv | 149 ++++++++++++++
 tb/tb_pipelined_skip_adder.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_skip_adder.sv
// Pipelined carry-skip adder/subtractor with a valid/ready stream interface.
// The N-bit datapath is cut into N/B skip blocks, grouped into P segments of
// S blocks each; pipeline stage k resolves segment k and hands the still
// unprocessed operand bits, the finished low sum bits and its carry onward.
module pipelined_skip_adder #(
    parameter int N = 32,
    parameter int B = 4,
    parameter int P = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         overflow,
    output logic         zero
);

    localparam int S  = N / (B * P);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = (P > 1) ? $clog2(P) : 1;

    logic [N-1:0] aPipe_q   [P];
    logic [N-1:0] aPipe_d   [P];
    logic [N-1:0] bPipe_q   [P];
    logic [N-1:0] bPipe_d   [P];
    logic [N-1:0] sumPipe_q [P];
    logic [N-1:0] sumPipe_d [P];
    logic [P-1:0] carryPipe_q;
    logic [P-1:0] carryPipe_d;
    logic [P-1:0] validPipe_q;
    logic [P-1:0] validPipe_d;
    logic         overflow_q;
    logic         overflow_d;
    logic         zero_q;
    logic         zero_d;
    logic         advance;

    // The whole pipe moves as one unit: it shifts unless a finished result is stuck at the output.
    assign advance   = !validPipe_q[P-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = validPipe_q[P-1];
    assign sum       = sumPipe_q[P-1];
    assign cout      = carryPipe_q[P-1];
    assign overflow  = overflow_q;
    assign zero      = zero_q;

    // Each stage ripples inside its blocks and skips the block carry when every bit propagates.
    always_comb begin
        logic [N-1:0]  opA;
        logic [N-1:0]  opB;
        logic [N-1:0]  partSum;
        logic [IW-1:0] bitIdx;
        logic          carry;
        logic          ripple;
        logic          blkProp;
        logic          pBit;
        logic          gBit;
        logic          carryIntoMsb;
        logic          stageValid;

        opA          = '0;
        opB          = '0;
        partSum      = '0;
        bitIdx       = '0;
        carry        = 1'b0;
        ripple       = 1'b0;
        blkProp      = 1'b0;
        pBit         = 1'b0;
        gBit         = 1'b0;
        carryIntoMsb = 1'b0;
        stageValid   = 1'b0;
        aPipe_d      = aPipe_q;
        bPipe_d      = bPipe_q;
        sumPipe_d    = sumPipe_q;
        carryPipe_d  = carryPipe_q;
        validPipe_d  = validPipe_q;

        for (int k = 0; k < P; k++) begin
            if (k == 0) begin
                opA        = a;
                opB        = sub ? ~b : b;
                partSum    = '0;
                carry      = sub;
                stageValid = in_valid;
            end else begin
                opA        = aPipe_q[PW'(k - 1)];
                opB        = bPipe_q[PW'(k - 1)];
                partSum    = sumPipe_q[PW'(k - 1)];
                carry      = carryPipe_q[PW'(k - 1)];
                stageValid = validPipe_q[PW'(k - 1)];
            end

            for (int j = 0; j < S; j++) begin
                ripple  = carry;
                blkProp = 1'b1;
                for (int i = 0; i < B; i++) begin
                    bitIdx          = IW'((k * S + j) * B + i);
                    pBit            = opA[bitIdx] ^ opB[bitIdx];
                    gBit            = opA[bitIdx] & opB[bitIdx];
                    partSum[bitIdx] = pBit ^ ripple;
                    if (bitIdx == IW'(N - 1)) begin
                        carryIntoMsb = ripple;
                    end
                    ripple  = gBit | (pBit & ripple);
                    blkProp = blkProp & pBit;
                end
                carry = blkProp ? carry : ripple;
            end

            aPipe_d[PW'(k)]     = opA;
            bPipe_d[PW'(k)]     = opB;
            sumPipe_d[PW'(k)]   = partSum;
            carryPipe_d[PW'(k)] = carry;
            validPipe_d[PW'(k)] = stageValid;
        end

        zero_d     = (partSum == '0);
        overflow_d = carryIntoMsb ^ carry;
    end

    // Stage registers: cleared by reset, loaded together on advance, otherwise frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aPipe_q     <= '{default: '0};
            bPipe_q     <= '{default: '0};
            sumPipe_q   <= '{default: '0};
            carryPipe_q <= '0;
            validPipe_q <= '0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else if (advance) begin
            aPipe_q     <= aPipe_d;
            bPipe_q     <= bPipe_d;
            sumPipe_q   <= sumPipe_d;
            carryPipe_q <= carryPipe_d;
            validPipe_q <= validPipe_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

endmodule

// File: tb/tb_pipelined_skip_adder.sv
// Self-checking bench for pipelined_skip_adder: directed corner cases on a
// 32/4/2 instance plus a randomized sweep over four parameter sets, all
// checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_pipelined_skip_adder;

    localparam int N = 32;
    localparam int P = 2;
    localparam int BEATS = 10000;
    localparam int SW [4] = '{8, 16, 32, 64};
    localparam int SP [4] = '{1, 4, 2, 8};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         inValid;
    logic         inReady;
    logic         outValid;
    logic         outReady;
    logic         sub;
    logic         cout;
    logic         overflow;
    logic         zero;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] sum;

    int checks = 0;
    int errors = 0;

    logic [63:0] swA;
    logic [63:0] swB;
    logic        swSub;
    logic        swInValid;
    logic        swOutReady;
    logic [3:0]  swInReady;
    logic [3:0]  swOutValid;
    logic [3:0]  swCout;
    logic [3:0]  swOverflow;
    logic [3:0]  swZero;
    logic [7:0]  s8Sum;
    logic [15:0] s16Sum;
    logic [31:0] s32Sum;
    logic [63:0] s64Sum;
    logic [63:0] swSum [4];

    always #5 clk = ~clk;

    pipelined_skip_adder #(.N(32), .B(4), .P(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady),
        .a(a), .b(b), .sub(sub), .out_valid(outValid), .out_ready(outReady),
        .sum(sum), .cout(cout), .overflow(overflow), .zero(zero)
    );

    pipelined_skip_adder #(.N(8), .B(4), .P(1)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(swInValid), .in_ready(swInReady[0]),
        .a(swA[7:0]), .b(swB[7:0]), .sub(swSub), .out_valid(swOutValid[0]), .out_ready(swOutReady),
        .sum(s8Sum), .cout(swCout[0]), .overflow(swOverflow[0]), .zero(swZero[0])
    );

    pipelined_skip_adder #(.N(16), .B(4), .P(4)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(swInValid), .in_ready(swInReady[1]),
        .a(swA[15:0]), .b(swB[15:0]), .sub(swSub), .out_valid(swOutValid[1]), .out_ready(swOutReady),
        .sum(s16Sum), .cout(swCout[1]), .overflow(swOverflow[1]), .zero(swZero[1])
    );

    pipelined_skip_adder #(.N(32), .B(8), .P(2)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(swInValid), .in_ready(swInReady[2]),
        .a(swA[31:0]), .b(swB[31:0]), .sub(swSub), .out_valid(swOutValid[2]), .out_ready(swOutReady),
        .sum(s32Sum), .cout(swCout[2]), .overflow(swOverflow[2]), .zero(swZero[2])
    );

    pipelined_skip_adder #(.N(64), .B(4), .P(8)) u64 (
        .clk(clk), .rst_n(rst_n), .in_valid(swInValid), .in_ready(swInReady[3]),
        .a(swA), .b(swB), .sub(swSub), .out_valid(swOutValid[3]), .out_ready(swOutReady),
        .sum(s64Sum), .cout(swCout[3]), .overflow(swOverflow[3]), .zero(swZero[3])
    );

    // Widen the sweep results so one loop can inspect every instance.
    always_comb begin
        swSum[0] = {56'd0, s8Sum};
        swSum[1] = {48'd0, s16Sum};
        swSum[2] = {32'd0, s32Sum};
        swSum[3] = s64Sum;
    end

    // Reference: integer add/subtract of n-bit operands, returns {cout, overflow, zero, sum}.
    function automatic logic [66:0] refModel(input logic [63:0] ai, input logic [63:0] bi,
                                             input logic si, input int n);
        logic [63:0] mask;
        logic [63:0] am;
        logic [63:0] bm;
        logic [63:0] s;
        logic [64:0] full;
        logic        c;
        logic        ov;
        logic        sa;
        logic        sb;
        logic        ss;
        mask = (n == 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
        am   = ai & mask;
        bm   = bi & mask;
        full = {1'b0, am} + {1'b0, bm};
        if (si) begin
            s = (am - bm) & mask;
            c = (am >= bm);
        end else begin
            s = full[63:0] & mask;
            c = full[n];
        end
        sa = am[n-1];
        sb = bm[n-1];
        ss = s[n-1];
        ov = si ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
        return {c, ov, (s == 64'd0), s};
    endfunction

    // Drive one beat into an open pipe, then wait (bounded) for its result.
    task automatic applyStimulus(input logic [31:0] ai, input logic [31:0] bi, input logic si,
                                 output logic [31:0] so, output logic co, output logic vo,
                                 output logic zo, output int lat);
        @(negedge clk);
        a        = ai;
        b        = bi;
        sub      = si;
        inValid  = 1'b1;
        outReady = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        inValid = 1'b0;
        while (!outValid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!outValid) lat = -1;
        so = sum;
        co = cout;
        vo = overflow;
        zo = zero;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (outValid !== 1'b0 || inReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_initial got valid=%b ready=%b exp valid=0 ready=1", outValid, inReady);
        end
        @(negedge clk);
        rst_n = 1'b1;
        outReady = 1'b0;
        inValid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a   = $urandom;
            b   = $urandom;
            sub = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        inValid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b exp 0", outValid); end
        checks++;
        if (sum !== 32'd0) begin errors++; $display("[TB] FAIL reset_sum got %h exp 0", sum); end
        checks++;
        if (cout !== 1'b0) begin errors++; $display("[TB] FAIL reset_cout got %b exp 0", cout); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got %b exp 0", overflow); end
        checks++;
        if (zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_zero got %b exp 0", zero); end
        checks++;
        if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b exp 1", inReady); end
        @(negedge clk);
        rst_n    = 1'b1;
        outReady = 1'b1;
    endtask

    task automatic test_full_propagate();
        logic [31:0] ta [2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] tb [2] = '{32'h0000_0000, 32'h0000_0001};
        logic [31:0] es [2] = '{32'hFFFF_FFFF, 32'h0000_0000};
        logic        ec [2] = '{1'b0, 1'b1};
        logic        ez [2] = '{1'b0, 1'b1};
        logic [31:0] so;
        logic        co, vo, zo;
        int          lat;
        for (int t = 0; t < 2; t++) begin
            applyStimulus(ta[t], tb[t], 1'b0, so, co, vo, zo, lat);
            checks++;
            if ({co, vo, zo, so} !== {ec[t], 1'b0, ez[t], es[t]}) begin
                errors++;
                $display("[TB] FAIL propagate_%0d got c=%b v=%b z=%b s=%h exp c=%b v=0 z=%b s=%h",
                         t, co, vo, zo, so, ec[t], ez[t], es[t]);
            end
            checks++;
            if (lat != P) begin errors++; $display("[TB] FAIL propagate_latency_%0d got %0d exp %0d", t, lat, P); end
        end
    endtask

    task automatic test_sub_overflow();
        logic [31:0] ta [3] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd5};
        logic [31:0] tb [3] = '{32'd1, 32'd1, 32'd7};
        logic        ts [3] = '{1'b0, 1'b1, 1'b1};
        logic [31:0] es [3] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
        logic        ec [3] = '{1'b0, 1'b1, 1'b0};
        logic        ev [3] = '{1'b1, 1'b1, 1'b0};
        logic [31:0] so;
        logic        co, vo, zo;
        int          lat;
        for (int t = 0; t < 3; t++) begin
            applyStimulus(ta[t], tb[t], ts[t], so, co, vo, zo, lat);
            checks++;
            if ({co, vo, zo, so} !== {ec[t], ev[t], 1'b0, es[t]}) begin
                errors++;
                $display("[TB] FAIL subovf_%0d got c=%b v=%b z=%b s=%h exp c=%b v=%b z=0 s=%h",
                         t, co, vo, zo, so, ec[t], ev[t], es[t]);
            end
            checks++;
            if (lat != P) begin errors++; $display("[TB] FAIL subovf_latency_%0d got %0d exp %0d", t, lat, P); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] da [10];
        logic [31:0] db [10];
        logic        ds [10];
        logic [34:0] expQ [$];
        logic [66:0] r;
        int          sent = 0;
        int          got  = 0;
        for (int i = 0; i < 10; i++) begin
            da[i] = $urandom;
            db[i] = $urandom;
            ds[i] = 1'($urandom_range(0, 1));
        end
        for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
            @(negedge clk);
            outReady = (cyc % 3 == 0);
            if (sent < 10) begin
                a = da[sent]; b = db[sent]; sub = ds[sent]; inValid = 1'b1;
            end else begin
                inValid = 1'b0;
            end
            #1;
            if (outValid) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL backpressure_extra got s=%h exp no beat", sum);
                end else begin
                    if ({cout, overflow, zero, sum} !== expQ[0]) begin
                        errors++;
                        $display("[TB] FAIL backpressure_data got %h exp %h", {cout, overflow, zero, sum}, expQ[0]);
                    end
                    if (outReady) begin
                        void'(expQ.pop_front());
                        got++;
                    end
                end
            end
            if (inValid && inReady) begin
                r = refModel({32'd0, da[sent]}, {32'd0, db[sent]}, ds[sent], 32);
                expQ.push_back({r[66:64], r[31:0]});
                sent++;
            end
        end
        @(negedge clk);
        inValid  = 1'b0;
        outReady = 1'b1;
        checks++;
        if (got != 10 || expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL backpressure_count got delivered=%0d left=%0d exp 10/0", got, expQ.size());
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] so;
        logic        co, vo, zo;
        int          lat;
        int          spurious = 0;
        @(negedge clk);
        outReady = 1'b0;
        inValid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        inValid = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        outReady = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (outValid) spurious++;
        end
        checks++;
        if (spurious != 0) begin errors++; $display("[TB] FAIL midreset_stale got %0d beats exp 0", spurious); end
        applyStimulus(32'd3, 32'd4, 1'b0, so, co, vo, zo, lat);
        checks++;
        if ({co, vo, zo, so} !== {3'b000, 32'd7}) begin
            errors++;
            $display("[TB] FAIL midreset_sum got c=%b v=%b z=%b s=%h exp s=7", co, vo, zo, so);
        end
        checks++;
        if (lat != P) begin errors++; $display("[TB] FAIL midreset_latency got %0d exp %0d", lat, P); end
    endtask

    task automatic test_sweep();
        logic [63:0] qa [$];
        logic [63:0] qb [$];
        logic        qs [$];
        int          qe [$];
        int          rd [4] = '{0, 0, 0, 0};
        int          edgeNo = -1;
        int          accepted = 0;
        int          pick;
        logic [66:0] expV;
        logic [66:0] gotV;
        swOutReady = 1'b1;
        for (int cyc = 0; cyc < 30000; cyc++) begin
            @(negedge clk);
            edgeNo++;
            for (int i = 0; i < 4; i++) begin
                if (swOutValid[i]) begin
                    checks++;
                    if (rd[i] >= qa.size()) begin
                        errors++;
                        $display("[TB] FAIL sweep_extra_n%0d got s=%h exp no beat", SW[i], swSum[i]);
                    end else begin
                        expV = refModel(qa[rd[i]], qb[rd[i]], qs[rd[i]], SW[i]);
                        gotV = {swCout[i], swOverflow[i], swZero[i], swSum[i]};
                        if (gotV !== expV) begin
                            errors++;
                            $display("[TB] FAIL sweep_data_n%0d got %h exp %h", SW[i], gotV, expV);
                        end
                        checks++;
                        if (edgeNo - qe[rd[i]] + 1 != SP[i]) begin
                            errors++;
                            $display("[TB] FAIL sweep_latency_n%0d got %0d exp %0d", SW[i], edgeNo - qe[rd[i]] + 1, SP[i]);
                        end
                        rd[i]++;
                    end
                end
            end
            checks++;
            if (swInReady !== 4'hF) begin errors++; $display("[TB] FAIL sweep_in_ready got %b exp 1111", swInReady); end
            if (accepted == BEATS && rd[0] == BEATS && rd[1] == BEATS && rd[2] == BEATS && rd[3] == BEATS) break;
            if (accepted < BEATS) begin
                pick = $urandom_range(0, 15);
                swA  = {$urandom, $urandom};
                swB  = {$urandom, $urandom};
                if (pick == 0) begin swA = {64{1'b1}}; swB = 64'd0; end
                if (pick == 1) begin swA = {64{1'b1}}; swB = 64'd1; end
                swSub     = 1'($urandom_range(0, 1));
                swInValid = ($urandom_range(0, 7) != 0);
                if (swInValid) begin
                    qa.push_back(swA);
                    qb.push_back(swB);
                    qs.push_back(swSub);
                    qe.push_back(edgeNo + 1);
                    accepted++;
                end
            end else begin
                swInValid = 1'b0;
            end
        end
        swInValid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd[i] != BEATS) begin
                errors++;
                $display("[TB] FAIL sweep_count_n%0d got %0d exp %0d", SW[i], rd[i], BEATS);
            end
        end
    endtask

    // Hard time limit so a wedged pipe still ends the run.
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog got timeout exp completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence.
    initial begin
        rst_n      = 1'b0;
        inValid    = 1'b0;
        outReady   = 1'b1;
        a          = '0;
        b          = '0;
        sub        = 1'b0;
        swA        = '0;
        swB        = '0;
        swSub      = 1'b0;
        swInValid  = 1'b0;
        swOutReady = 1'b1;
        test_reset();
        test_full_propagate();
        test_sub_overflow();
        test_backpressure();
        test_mid_reset();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
